iq_impairment_pipe: RTL and testbench

Pipelined, parametrised I/Q impairment generator: applies a programmable gain mismatch to Q, then rotates (I, Q) by a programmable phase angle, all in signed fixed point with rounding and saturation. Successor to the fixed-coefficient combinational mismatch model. It sits in the transmit/receive impairment chain between sample source and DUT, with valid/ready streaming and a shadow-register config port for glitch-free coefficient updates.

---
 rtl/iq_impairment_pipe.sv | 189 ++++++++++++++++++
 tb/tb_iq_impairment_pipe.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_impairment_pipe.sv
// Three-stage I/Q impairment pipe: Q gain mismatch, then phase rotation, with rounding and saturation.
// Optional DC offsets on I and Q are enabled by defining IQ_IMPAIR_DC_OFFSET_EN.
module iq_impairment_pipe #(
    parameter int DW        = 16,
    parameter int CW        = 16,
    parameter int SATW      = 16,
    parameter int GAIN_INIT = 2**(CW-1)-1,
    parameter int COS_INIT  = 2**(CW-1)-1,
    parameter int SIN_INIT  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   i_in,
    input  logic [DW-1:0]   q_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   i_out,
    output logic [DW-1:0]   q_out,
    input  logic            cfg_wr,
    input  logic [2:0]      cfg_addr,
    input  logic [CW-1:0]   cfg_data,
    input  logic            cfg_commit,
    input  logic            sat_clr,
    output logic [SATW-1:0] sat_cnt
);

    localparam int PW = DW + CW;
    localparam int XW = DW + CW + 2;
    localparam logic signed [XW-1:0] HALF = XW'(2**(CW-2));
    localparam logic signed [XW-1:0] MAXV = {{(XW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [XW-1:0] MINV = {{(XW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [CW-1:0] GAIN_RST = CW'(GAIN_INIT);
    localparam logic [CW-1:0] COS_RST  = CW'(COS_INIT);
    localparam logic [CW-1:0] SIN_RST  = CW'(SIN_INIT);

    function automatic logic signed [XW-1:0] ext_p(input logic signed [PW-1:0] x);
        return {{(XW-PW){x[PW-1]}}, x};
    endfunction

    function automatic logic signed [XW-1:0] rnd(input logic signed [XW-1:0] x);
        return (x + HALF) >>> (CW-1);
    endfunction

    function automatic logic [DW-1:0] clamp(input logic signed [XW-1:0] x);
        if (x > MAXV)      return MAXV[DW-1:0];
        else if (x < MINV) return MINV[DW-1:0];
        else               return x[DW-1:0];
    endfunction

    // Shadow registers take cfg writes; active registers feed stage 1 and change only on commit.
    logic signed [CW-1:0] gain_s, cos_s, sin_s, gain_a, cos_a, sin_a;
`ifdef IQ_IMPAIR_DC_OFFSET_EN
    logic signed [DW-1:0] offi_s, offq_s, offi_a, offq_a, offi1, offq1, offi2, offq2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gain_s <= GAIN_RST;
            cos_s  <= COS_RST;
            sin_s  <= SIN_RST;
            gain_a <= GAIN_RST;
            cos_a  <= COS_RST;
            sin_a  <= SIN_RST;
`ifdef IQ_IMPAIR_DC_OFFSET_EN
            offi_s <= '0;
            offq_s <= '0;
            offi_a <= '0;
            offq_a <= '0;
`endif
        end else begin
            if (cfg_commit) begin
                gain_a <= gain_s;
                cos_a  <= cos_s;
                sin_a  <= sin_s;
`ifdef IQ_IMPAIR_DC_OFFSET_EN
                offi_a <= offi_s;
                offq_a <= offq_s;
`endif
            end
            if (cfg_wr) begin
                case (cfg_addr)
                    3'd0: gain_s <= cfg_data;
                    3'd1: cos_s  <= cfg_data;
                    3'd2: sin_s  <= cfg_data;
`ifdef IQ_IMPAIR_DC_OFFSET_EN
                    3'd3: offi_s <= cfg_data[DW-1:0];
                    3'd4: offq_s <= cfg_data[DW-1:0];
`endif
                    default: ;
                endcase
            end
        end
    end

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage 1 datapath: Q gain, rounded and clamped back to DW bits.
    logic signed [PW-1:0] q_in_x, gain_x, q_prod;
    logic [DW-1:0]        qs_next;
    assign q_in_x  = {{CW{q_in[DW-1]}}, q_in};
    assign gain_x  = {{DW{gain_a[CW-1]}}, gain_a};
    assign q_prod  = q_in_x * gain_x;
    assign qs_next = clamp(rnd(ext_p(q_prod)));

    logic                 v1, v2;
    logic signed [DW-1:0] i1, qs1;
    logic signed [CW-1:0] cos1, sin1;
    logic signed [PW-1:0] i1_x, qs1_x, cos1_x, sin1_x;
    logic signed [PW-1:0] p_ic, p_qs, p_is, p_qc;
    assign i1_x   = {{CW{i1[DW-1]}}, i1};
    assign qs1_x  = {{CW{qs1[DW-1]}}, qs1};
    assign cos1_x = {{DW{cos1[CW-1]}}, cos1};
    assign sin1_x = {{DW{sin1[CW-1]}}, sin1};

    // Stage 3 datapath: rotation sums, rounding, optional offset, saturation.
    logic signed [XW-1:0] sum_i, sum_q, i_pre, q_pre;
    logic                 sat_i, sat_q;
    assign sum_i = ext_p(p_ic) - ext_p(p_qs);
    assign sum_q = ext_p(p_is) + ext_p(p_qc);
`ifdef IQ_IMPAIR_DC_OFFSET_EN
    assign i_pre = rnd(sum_i) + {{(XW-DW){offi2[DW-1]}}, offi2};
    assign q_pre = rnd(sum_q) + {{(XW-DW){offq2[DW-1]}}, offq2};
`else
    assign i_pre = rnd(sum_i);
    assign q_pre = rnd(sum_q);
`endif
    assign sat_i = (i_pre > MAXV) || (i_pre < MINV);
    assign sat_q = (q_pre > MAXV) || (q_pre < MINV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            i1        <= '0;
            qs1       <= '0;
            cos1      <= '0;
            sin1      <= '0;
            v2        <= 1'b0;
            p_ic      <= '0;
            p_qs      <= '0;
            p_is      <= '0;
            p_qc      <= '0;
            out_valid <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
`ifdef IQ_IMPAIR_DC_OFFSET_EN
            offi1     <= '0;
            offq1     <= '0;
            offi2     <= '0;
            offq2     <= '0;
`endif
        end else if (en) begin
            v1        <= in_valid;
            i1        <= $signed(i_in);
            qs1       <= $signed(qs_next);
            cos1      <= cos_a;
            sin1      <= sin_a;
            v2        <= v1;
            p_ic      <= i1_x * cos1_x;
            p_qs      <= qs1_x * sin1_x;
            p_is      <= i1_x * sin1_x;
            p_qc      <= qs1_x * cos1_x;
            out_valid <= v2;
            i_out     <= clamp(i_pre);
            q_out     <= clamp(q_pre);
`ifdef IQ_IMPAIR_DC_OFFSET_EN
            offi1     <= offi_a;
            offq1     <= offq_a;
            offi2     <= offi1;
            offq2     <= offq1;
`endif
        end
    end

    // Counts once per sample entering the output register; clear has priority and the count sticks at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end else if (en && v2 && (sat_i || sat_q) && (sat_cnt != {SATW{1'b1}})) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_iq_impairment_pipe.sv
// Bench for iq_impairment_pipe: arithmetic reference model with expected queue plus directed literal checks.
// Honours IQ_IMPAIR_DC_OFFSET_EN the same way as the design.
module tb_iq_impairment_pipe;

    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int SATW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   i_in = '0;
    logic [DW-1:0]   q_in = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [DW-1:0]   i_out;
    logic [DW-1:0]   q_out;
    logic            cfg_wr = 1'b0;
    logic [2:0]      cfg_addr = '0;
    logic [CW-1:0]   cfg_data = '0;
    logic            cfg_commit = 1'b0;
    logic            sat_clr = 1'b0;
    logic [SATW-1:0] sat_cnt;

    iq_impairment_pipe #(.DW(DW), .CW(CW), .SATW(SATW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .i_in(i_in), .q_in(q_in),
        .out_valid(out_valid), .out_ready(out_ready), .i_out(i_out), .q_out(q_out),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
        .sat_clr(sat_clr), .sat_cnt(sat_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [2*DW-1:0] exp_q[$];
    logic [2*DW-1:0] got_q[$];
    int sh[5];
    int act[5];
    bit rand_rdy = 1'b0;

    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    function automatic longint sat_l(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    // Reference: Q gain, rotate, round half up, optional offset, clamp.
    function automatic logic [2*DW-1:0] model(input int i, input int q);
        longint qs, si, sq, ri, rq, half, offi, offq;
        logic [63:0] ti, tq;
        half = longint'(1) << (CW-2);
        qs = sat_l((longint'(q) * act[0] + half) >>> (CW-1));
        si = longint'(i) * act[1] - qs * act[2];
        sq = longint'(i) * act[2] + qs * act[1];
`ifdef IQ_IMPAIR_DC_OFFSET_EN
        offi = act[3];
        offq = act[4];
`else
        offi = 0;
        offq = 0;
`endif
        ri = ((si + half) >>> (CW-1)) + offi;
        rq = ((sq + half) >>> (CW-1)) + offq;
        ti = sat_l(ri);
        tq = sat_l(rq);
        return {ti[DW-1:0], tq[DW-1:0]};
    endfunction

    // compare process (scoreboard)
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            sh = '{32767, 32767, 0, 0, 0};
            act = sh;
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_sat_cnt", 32'(sat_cnt), 0);
            chk("rst_in_ready", 32'(in_ready), 1);
        end else begin
            chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out got=%h want=none t=%0t", {i_out, q_out}, $time);
                end else begin
                    chk("out_sample", {i_out, q_out}, exp_q.pop_front());
                end
                got_q.push_back({i_out, q_out});
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(int'($signed(i_in)), int'($signed(q_in))));
            if (cfg_commit) act = sh;
            if (cfg_wr && cfg_addr < 3'd5) sh[cfg_addr] = int'($signed(cfg_data));
        end
    end

    // driver tasks
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input int q);
        int n = 0;
        in_valid = 1'b1;
        i_in = i[DW-1:0];
        q_in = q[DW-1:0];
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=stalled want=accepted");
        end
        sync();
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input int a, input int d);
        cfg_wr = 1'b1;
        cfg_addr = a[2:0];
        cfg_data = d[CW-1:0];
        sync();
        cfg_wr = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        sync();
        cfg_commit = 1'b0;
    endtask

    task automatic expect_out(input string name, input int ei, input int eq);
        int n = 0;
        logic [DW-1:0] a, b;
        while (got_q.size() == 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (got_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s got=timeout want=output", name);
        end else begin
            a = ei[DW-1:0];
            b = eq[DW-1:0];
            chk(name, got_q.pop_front(), {a, b});
        end
        sync();
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        sync();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_i_out", 32'(i_out), 0);
        chk("reset_q_out", 32'(q_out), 0);
        rst_n = 1'b1;
        sync();

        // basic half-scale gain and rotation, latency
        cfg_write(0, 16384);
        cfg_write(1, 16384);
        cfg_write(2, 0);
        commit();
        send(1000, 2000);
        n = 0;
        while (!out_valid && n < 10) begin
            sync();
            n++;
        end
        chk("latency", n, 2);
        expect_out("half_scale", 500, 500);
        chk("sat_after_half", 32'(sat_cnt), 0);

        // full-scale: I cancels to 1, Q saturates
        cfg_write(0, 32767);
        cfg_write(1, 32767);
        cfg_write(2, 32767);
        commit();
        send(32767, 32767);
        expect_out("full_scale", 1, 32767);
        wait_drain();
        chk("sat_one", 32'(sat_cnt), 1);

        // clear on the increment cycle wins
        send(32767, 32767);
        sync();
        sat_clr = 1'b1;
        sync();
        sat_clr = 1'b0;
        expect_out("full_scale_clr", 1, 32767);
        chk("sat_clr_wins", 32'(sat_cnt), 0);

        // sticky at max
        for (int k = 0; k < 9; k++) send(32767, 32767);
        wait_drain();
        chk("sat_sticky", 32'(sat_cnt), 7);
        sat_clr = 1'b1;
        sync();
        sat_clr = 1'b0;
        chk("sat_cleared", 32'(sat_cnt), 0);
        got_q.delete();

        // backpressure stream
        cfg_write(0, 23170);
        cfg_write(1, 23170);
        cfg_write(2, -23170);
        commit();
        rand_rdy = 1'b1;
        for (int k = 0; k < 20; k++) send(k * 3203 - 30000, 31000 - k * 2917);
        wait_drain();
        rand_rdy = 1'b0;
        sync();
        chk("stream_count", got_q.size(), 20);
        got_q.delete();

        // commit coincident with sample N
        cfg_write(0, 16384);
        cfg_write(1, 16384);
        cfg_write(2, 0);
        commit();
        cfg_wr = 1'b1;
        cfg_addr = 3'd2;
        cfg_data = 16'd8192;
        send(1000, 2000);
        cfg_wr = 1'b0;
        cfg_commit = 1'b1;
        send(1000, 2000);
        cfg_commit = 1'b0;
        send(1000, 2000);
        expect_out("pre_write", 500, 500);
        expect_out("commit_cycle_old", 500, 500);
        expect_out("after_commit_new", 250, 750);
        cfg_wr = 1'b1;
        cfg_addr = 3'd2;
        cfg_data = 16'd0;
        send(1000, 2000);
        cfg_wr = 1'b0;
        expect_out("write_no_commit", 250, 750);

        // reset with samples in flight
        send(100, 200);
        send(300, 400);
        send(500, 600);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_q_out", 32'(q_out), 0);
        sync();
        sync();
        rst_n = 1'b1;
        got_q.delete();
        repeat (10) sync();
        chk("midrst_no_emit", got_q.size(), 0);
        chk("midrst_sat", 32'(sat_cnt), 0);
        send(1000, 2000);
        expect_out("init_coeffs", 1000, 2000);

        // DC offset on I
        cfg_write(3, 100);
        cfg_write(0, 16384);
        cfg_write(1, 16384);
        cfg_write(2, 0);
        commit();
        send(1000, 2000);
`ifdef IQ_IMPAIR_DC_OFFSET_EN
        expect_out("dc_offset", 600, 500);
`else
        expect_out("dc_offset", 500, 500);
`endif
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
